// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the line-fetch FSM state constants.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // AXSIZE encoding for a full-width beat of the given bus width.
  function automatic logic [2:0] size_of(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_line_fetch.sv
// AXI4 read initiator: fetches one cache line per request with a single INCR
// burst and returns the assembled line together with a sticky error flag.
module axi_line_fetch
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int LINE_WORDS = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] rsp_line,
  output logic                             rsp_err,
  output logic [ID_WIDTH-1:0]              m_axi_arid,
  output logic [ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                       m_axi_arlen,
  output logic [2:0]                       m_axi_arsize,
  output logic [1:0]                       m_axi_arburst,
  output logic                             m_axi_arvalid,
  input  logic                             m_axi_arready,
  input  logic [ID_WIDTH-1:0]              m_axi_rid,
  input  logic [DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                       m_axi_rresp,
  input  logic                             m_axi_rlast,
  input  logic                             m_axi_rvalid,
  output logic                             m_axi_rready
);

  localparam int LINE_BYTES = LINE_WORDS * DATA_WIDTH / 8;
  localparam int CW         = $clog2(LINE_WORDS) + 1;

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [CW-1:0]         LAST_IDX    = CW'(LINE_WORDS - 1);
  localparam logic [CW-1:0]         FULL        = CW'(LINE_WORDS);
  localparam logic [ID_WIDTH-1:0]   OWN_ID      = ID_WIDTH'(AXI_ID);

  logic [1:0]            state_reg;
  logic                  req_ready_reg;
  logic                  arvalid_reg;
  logic [ADDR_WIDTH-1:0] araddr_reg;
  logic                  rready_reg;
  logic                  rsp_valid_reg;
  logic                  err_reg;
  logic [CW-1:0]         cnt_reg;
  logic [DATA_WIDTH-1:0] line_reg [LINE_WORDS];

  logic beat;
  logic beat_err;

  assign beat = (state_reg == ST_DATA) && m_axi_rvalid && rready_reg;

  // A beat is bad if its response/ID is wrong, rlast is misplaced, or it
  // arrives after the line is already full.
  assign beat_err = (m_axi_rresp != RESP_OKAY)
                 || (m_axi_rid != OWN_ID)
                 || (m_axi_rlast && (cnt_reg != LAST_IDX))
                 || (cnt_reg >= FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      req_ready_reg <= 1'b1;
      arvalid_reg   <= 1'b0;
      araddr_reg    <= '0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            araddr_reg    <= req_addr & ~OFFSET_MASK;
            arvalid_reg   <= 1'b1;
            req_ready_reg <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            if (cnt_reg != FULL) cnt_reg <= cnt_reg + 1'b1;
            if (beat_err) err_reg <= 1'b1;
            if (m_axi_rlast) begin
              rready_reg    <= 1'b0;
              rsp_valid_reg <= 1'b1;
              state_reg     <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Line buffer has no reset; each word is written only by its own beat slot,
  // so saturated (overflow) beats never land anywhere.
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line
    always_ff @(posedge clk) begin
      if (beat && (cnt_reg == CW'(gi))) line_reg[gi] <= m_axi_rdata;
    end
    assign rsp_line[gi*DATA_WIDTH +: DATA_WIDTH] = line_reg[gi];
  end

  assign req_ready     = req_ready_reg;
  assign rsp_valid     = rsp_valid_reg;
  assign rsp_err       = err_reg;
  assign m_axi_arid    = OWN_ID;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arlen   = 8'(LINE_WORDS - 1);
  assign m_axi_arsize  = size_of(DATA_WIDTH);
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_axi_line_fetch.sv
// Directed + randomized bench for axi_line_fetch; the bench itself plays the
// AXI RAM responder and predicts each line from its own memory image.
module tb_axi_line_fetch;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 8;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [LW*DW-1:0] rsp_line;
  logic            rsp_err;
  logic [IW-1:0]   m_axi_arid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [IW-1:0]   m_axi_rid;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rlast;
  logic            m_axi_rvalid;
  logic            m_axi_rready;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mem [0:255];

  axi_line_fetch #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .LINE_WORDS(LW), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_line(rsp_line), .rsp_err(rsp_err),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW*DW-1:0] obs, input logic [LW*DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_arvalid"}, m_axi_arvalid, 0);
    check({tag, "_rready"}, m_axi_rready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_araddr"}, m_axi_araddr, 0);
  endtask

  // One refill transaction. last_at = beat index carrying rlast; abort_after > 0
  // pulses reset once that many beats have been taken.
  task automatic run_fill(input logic [31:0] addr, input int ar_delay, input int gap_max,
                          input int bad_resp_beat, input int bad_id_beat, input int last_at,
                          input int stall, input int abort_after, input bit measure);
    logic [31:0]      exp_addr;
    logic [LW*DW-1:0] exp_line, mask, held;
    bit               exp_err;
    int               base, nb, cyc, gaps;

    exp_addr = addr & ~32'h1F;
    base     = int'(exp_addr >> 2);
    nb       = last_at + 1;
    exp_err  = (last_at != LW - 1);

    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    cyc       = 1;
    check("arvalid_latency", m_axi_arvalid, 1);
    check("req_ready_busy", req_ready, 0);
    check("araddr", m_axi_araddr, exp_addr);
    check("arlen", m_axi_arlen, LW - 1);
    check("arsize", m_axi_arsize, 2);
    check("arburst", m_axi_arburst, 1);
    check("arid", m_axi_arid, 0);

    for (int i = 0; i < ar_delay; i++) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = $urandom;
      tick();
      cyc++;
      check("arvalid_hold", m_axi_arvalid, 1);
      check("araddr_hold", m_axi_araddr, exp_addr);
      check("rready_in_addr", m_axi_rready, 0);
    end
    m_axi_rvalid  = 1'b0;
    m_axi_arready = 1'b1;
    tick();
    cyc++;
    m_axi_arready = 1'b0;
    check("arvalid_drop", m_axi_arvalid, 0);
    check("rready_rise", m_axi_rready, 1);

    for (int b = 0; b < nb; b++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gaps; g++) begin
        m_axi_rvalid = 1'b0;
        tick();
        cyc++;
      end
      check("rready_beat", m_axi_rready, 1);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = mem[base + b];
      m_axi_rresp  = (b == bad_resp_beat) ? 2'b10 : 2'b00;
      m_axi_rid    = (b == bad_id_beat) ? 8'h5A : 8'h00;
      m_axi_rlast  = (b == last_at);
      if (b == bad_resp_beat || b == bad_id_beat) exp_err = 1'b1;
      tick();
      cyc++;
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
      m_axi_rid    = 8'h00;
      if (abort_after == b + 1) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("after_abort");
        $display("fill addr=%h aborted by reset after %0d beats", addr, b + 1);
        return;
      end
    end

    check("rsp_valid_rise", rsp_valid, 1);
    check("rready_fall", m_axi_rready, 0);
    check("rsp_err", rsp_err, exp_err);
    if (measure) check("latency_min", cyc >= LW + 1, 1);

    exp_line = '0;
    mask     = '0;
    for (int k = 0; k < nb; k++) begin
      exp_line[k*DW +: DW] = mem[base + k];
      mask[k*DW +: DW]     = '1;
    end
    check("rsp_line", rsp_line & mask, exp_line);
    held = rsp_line;

    if (last_at != LW - 1) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = ~mem[base];
      m_axi_rlast  = 1'b1;
      tick();
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      check("extra_beat_rready", m_axi_rready, 0);
      check("extra_beat_line", rsp_line, held);
    end

    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1;
      req_addr  = $urandom;
      tick();
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_req_ready", req_ready, 0);
      check("stall_line", rsp_line, held);
      check("stall_err", rsp_err, exp_err);
    end

    rsp_ready = 1'b1;
    req_valid = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("rsp_valid_fall", rsp_valid, 0);
    check("req_ready_back", req_ready, 1);
    check("no_accept_in_resp", m_axi_arvalid, 0);
    $display("fill addr=%h araddr=%h beats=%0d err=%0d exp_err=%0d cycles=%0d",
             addr, exp_addr, nb, rsp_err, exp_err, cyc);
  endtask

  initial begin
    int ra, rd, rg, rk, rb;
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("post_reset");

    run_fill(32'h40, 0, 0, -1, -1, 7, 0, -1, 1);   // basic fill
    run_fill(32'h5C, 0, 0, -1, -1, 7, 0, -1, 1);   // unaligned
    run_fill(32'h80, 5, 3, -1, -1, 7, 0, -1, 0);   // backpressure
    run_fill(32'hA0, 0, 1, 3, -1, 7, 0, -1, 0);    // SLVERR on beat 3
    run_fill(32'hC0, 1, 0, -1, -1, 5, 0, -1, 0);   // early rlast
    run_fill(32'hE0, 0, 0, -1, -1, 7, 0, 4, 0);    // reset mid-burst
    run_fill(32'h100, 0, 0, -1, -1, 7, 0, -1, 0);  // clean after reset
    run_fill(32'h120, 0, 0, -1, -1, 7, 10, -1, 0); // consumer stall
    run_fill(32'h140, 2, 2, -1, 2, 7, 0, -1, 0);   // bad RID

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int t = 0; t < 8; t++) begin
      ra = int'($urandom_range(0, 32'h3FF));
      rd = int'($urandom_range(0, 4));
      rg = int'($urandom_range(0, 3));
      rk = int'($urandom_range(0, 3));
      rb = int'($urandom_range(0, LW - 1));
      case (rk)
        0: run_fill(32'(ra), rd, rg, -1, -1, 7, rd, -1, 0);
        1: run_fill(32'(ra), rd, rg, rb, -1, 7, 0, -1, 0);
        2: run_fill(32'(ra), rd, rg, -1, rb, 7, 0, -1, 0);
        default: run_fill(32'(ra), rd, rg, -1, -1, rb, rg, -1, 0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
